// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the alu issue stage: default widths, ALU opcodes
// and the legal-opcode test used to flag unsupported operations.
package alu_issue_stage_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned ADDR_WIDTH_DEF = 5;

    typedef enum logic [2:0] {
        ALUOP_AND = 3'b000,
        ALUOP_OR  = 3'b001,
        ALUOP_ADD = 3'b010,
        ALUOP_SUB = 3'b110,
        ALUOP_SLT = 3'b111
    } aluop_e;

    function automatic logic is_legal_aluop(input logic [2:0] op);
        logic legal;
        case (op)
            ALUOP_AND, ALUOP_OR, ALUOP_ADD, ALUOP_SUB, ALUOP_SLT: legal = 1'b1;
            default:                                              legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_issue_stage_reg_file.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port, r0 hard-wired to zero, synchronous active-low clear.
module reg_file
    import alu_issue_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_raddr1,
    input  logic [ADDR_WIDTH-1:0] i_raddr2,
    output logic [DATA_WIDTH-1:0] o_rdata1,
    output logic [DATA_WIDTH-1:0] o_rdata2,
    input  logic                  i_wen,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata
);

    localparam int unsigned NREG = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [NREG];

    // Clear on reset, otherwise write any register except r0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mem <= '{default: '0};
        end else if (i_wen && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_mem[i_raddr1];
    assign o_rdata2 = (i_raddr2 == '0) ? '0 : r_mem[i_raddr2];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand issue stage in front of the alu: register file read with
// writeback forwarding, per-register pending scoreboard for RAW/WAW stalls,
// and a one-entry valid/ready output register driving A/B/ALUop.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_raddr1,
    input  logic [ADDR_WIDTH-1:0] in_raddr2,
    input  logic [ADDR_WIDTH-1:0] in_waddr,
    input  logic                  in_wen,
    input  logic [2:0]            in_aluop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] B,
    output logic [2:0]            ALUop,
    output logic [ADDR_WIDTH-1:0] out_waddr,
    output logic                  out_wen,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  err_illegal_op
);

    localparam int unsigned NREG = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] w_rf_rd1;
    logic [DATA_WIDTH-1:0] w_rf_rd2;
    logic [DATA_WIDTH-1:0] w_opa;
    logic [DATA_WIDTH-1:0] w_opb;
    logic                  w_wb_hit1;
    logic                  w_wb_hit2;
    logic                  w_wb_hitw;
    logic                  w_haz1;
    logic                  w_haz2;
    logic                  w_hazw;
    logic                  w_hazard;
    logic                  w_accept;
    logic [NREG-1:0]       w_pend_nxt;

    logic [NREG-1:0]       r_pend;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [2:0]            r_aluop;
    logic [ADDR_WIDTH-1:0] r_out_waddr;
    logic                  r_out_wen;
    logic                  r_err;

    reg_file #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .i_raddr1 (in_raddr1),
        .i_raddr2 (in_raddr2),
        .o_rdata1 (w_rf_rd1),
        .o_rdata2 (w_rf_rd2),
        .i_wen    (wb_en),
        .i_waddr  (wb_addr),
        .i_wdata  (wb_data)
    );

    assign w_wb_hit1 = wb_en && (wb_addr == in_raddr1);
    assign w_wb_hit2 = wb_en && (wb_addr == in_raddr2);
    assign w_wb_hitw = wb_en && (wb_addr == in_waddr);

    // r0 is already zero from the register file; forward only nonzero indices.
    assign w_opa = (in_raddr1 == '0) ? '0 : (w_wb_hit1 ? wb_data : w_rf_rd1);
    assign w_opb = (in_raddr2 == '0) ? '0 : (w_wb_hit2 ? wb_data : w_rf_rd2);

    // A writeback landing this cycle resolves the hazard it would otherwise cause.
    assign w_haz1   = (in_raddr1 != '0) && r_pend[in_raddr1] && !w_wb_hit1;
    assign w_haz2   = (in_raddr2 != '0) && r_pend[in_raddr2] && !w_wb_hit2;
    assign w_hazw   = in_wen && (in_waddr != '0) && r_pend[in_waddr] && !w_wb_hitw;
    assign w_hazard = w_haz1 || w_haz2 || w_hazw;

    assign in_ready = (!r_out_valid || out_ready) && !w_hazard;
    assign w_accept = in_valid && in_ready;

    // Scoreboard update: retire on writeback, then claim for the new writer so set wins.
    always_comb begin
        w_pend_nxt = r_pend;
        if (wb_en && (wb_addr != '0)) begin
            w_pend_nxt[wb_addr] = 1'b0;
        end
        if (w_accept && in_wen && (in_waddr != '0)) begin
            w_pend_nxt[in_waddr] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    // Output register: load on accept, drop valid when consumed without refill, hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_aluop     <= ALUOP_AND;
            r_out_waddr <= '0;
            r_out_wen   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_a         <= w_opa;
            r_b         <= w_opb;
            r_aluop     <= in_aluop;
            r_out_waddr <= in_waddr;
            r_out_wen   <= in_wen;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Sticky flag for any accepted opcode the alu does not implement.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_accept && !is_legal_aluop(in_aluop)) begin
            r_err <= 1'b1;
        end
    end

    assign out_valid      = r_out_valid;
    assign A              = r_a;
    assign B              = r_b;
    assign ALUop          = r_aluop;
    assign out_waddr      = r_out_waddr;
    assign out_wen        = r_out_wen;
    assign err_illegal_op = r_err;

endmodule
